// File: rtl/PARAMS_pkg.sv
// Shared widths, default latency and type definitions for the memory arbiter.
package PARAMS_pkg;

  localparam int ADDR_SIZE       = 32;
  localparam int WD_SIZE         = 32;
  localparam int MEM_LATENCY_DEF = 3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } mem_arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } mem_req_id_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin selector: bit 0 is the instruction side, bit 1 the data side.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  input  logic       i_enable,
  output logic [1:0] o_grant
);

  // i_last = 1 means the data side was granted most recently.
  always_comb begin
    o_grant = '0;
    if (i_enable) begin
      if (i_req == 2'b11) o_grant = i_last ? 2'b01 : 2'b10;
      else                o_grant = i_req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction and data requests onto a single fixed-latency memory port.
module mem_arbiter
  import PARAMS_pkg::*;
#(
  parameter int MEM_LATENCY = MEM_LATENCY_DEF,
  parameter int CNT_W       = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req_valid,
  input  logic [ADDR_SIZE-1:0] i_req_addr,
  output logic                 i_req_ready,
  output logic                 i_rsp_valid,
  input  logic                 d_req_valid,
  input  logic                 d_req_wr,
  input  logic [ADDR_SIZE-1:0] d_req_addr,
  input  logic [WD_SIZE-1:0]   d_req_wdata,
  output logic                 d_req_ready,
  output logic                 d_rsp_valid,
  output logic [WD_SIZE-1:0]   rsp_rdata,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic                 mem_rd_wr,
  output logic                 mem_op_en,
  output logic [WD_SIZE-1:0]   mem_wr_data,
  input  logic [WD_SIZE-1:0]   mem_rd_data
);

  mem_arb_state_t       r_state;
  logic [CNT_W-1:0]     r_cnt;
  mem_req_id_t          r_last;
  mem_req_id_t          r_id;
  logic                 r_wr;
  logic [ADDR_SIZE-1:0] r_addr;
  logic [WD_SIZE-1:0]   r_wdata;
  logic [WD_SIZE-1:0]   r_rdata;
  logic [1:0]           w_grant;
  logic                 w_can_grant;

  // Granting is suppressed while reset is asserted so the reset cycle stays quiet.
  assign w_can_grant = (r_state == IDLE) && reset_n;

  rr_arb2 u_rr_arb2 (
    .i_req    ({d_req_valid, i_req_valid}),
    .i_last   (r_last == REQ_D),
    .i_enable (w_can_grant),
    .o_grant  (w_grant)
  );

  assign i_req_ready = w_grant[0];
  assign d_req_ready = w_grant[1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= REQ_D;
      r_id    <= REQ_I;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant != 2'b00) begin
            r_id    <= w_grant[1] ? REQ_D : REQ_I;
            r_last  <= w_grant[1] ? REQ_D : REQ_I;
            r_wr    <= w_grant[1] & d_req_wr;
            r_addr  <= w_grant[1] ? d_req_addr : i_req_addr;
            r_wdata <= w_grant[1] ? d_req_wdata : '0;
            r_cnt   <= CNT_W'(MEM_LATENCY - 1);
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == '0) r_state <= ACCESS;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        ACCESS: begin
          if (!r_wr) r_rdata <= mem_rd_data;
          r_state <= RESP;
        end
        RESP: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_op_en   = (r_state == ACCESS);
  assign mem_rd_wr   = (r_state == ACCESS) && r_wr;
  assign mem_addr    = r_addr;
  assign mem_wr_data = r_wdata;
  assign i_rsp_valid = (r_state == RESP) && (r_id == REQ_I);
  assign d_rsp_valid = (r_state == RESP) && (r_id == REQ_D);
  assign rsp_rdata   = r_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model plus directed scenarios.
module tb_mem_arbiter;

  localparam int L = 3;

  logic        clk;
  logic        reset_n;
  logic        i_req_valid, d_req_valid, d_req_wr;
  logic [31:0] i_req_addr, d_req_addr, d_req_wdata;
  logic        i_req_ready, i_rsp_valid, d_req_ready, d_rsp_valid;
  logic [31:0] rsp_rdata, mem_addr, mem_wr_data, mem_rd_data;
  logic        mem_rd_wr, mem_op_en;

  logic        i1_valid, d1_valid, d1_wr;
  logic [31:0] i1_addr, d1_addr, d1_wdata;
  logic        i1_ready, i1_rsp, d1_ready, d1_rsp;
  logic [31:0] rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        mem_rw1, mem_en1;

  logic [31:0] mem_dut [0:255];
  logic [31:0] ref_mem [logic [31:0]];

  assign mem_rd_data = mem_dut[mem_addr[7:0]];
  assign mem_rdata1  = mem_dut[mem_addr1[7:0]];

  mem_arbiter #(.MEM_LATENCY(L), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .i_rsp_valid(i_rsp_valid),
    .d_req_valid(d_req_valid), .d_req_wr(d_req_wr), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready), .d_rsp_valid(d_rsp_valid),
    .rsp_rdata(rsp_rdata), .mem_addr(mem_addr), .mem_rd_wr(mem_rd_wr),
    .mem_op_en(mem_op_en), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  mem_arbiter #(.MEM_LATENCY(1), .CNT_W(4)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .i_req_valid(i1_valid), .i_req_addr(i1_addr), .i_req_ready(i1_ready),
    .i_rsp_valid(i1_rsp),
    .d_req_valid(d1_valid), .d_req_wr(d1_wr), .d_req_addr(d1_addr),
    .d_req_wdata(d1_wdata), .d_req_ready(d1_ready), .d_rsp_valid(d1_rsp),
    .rsp_rdata(rdata1), .mem_addr(mem_addr1), .mem_rd_wr(mem_rw1),
    .mem_op_en(mem_en1), .mem_wr_data(mem_wdata1), .mem_rd_data(mem_rdata1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: a transaction granted in cycle T owns the port until T+L+2.
  bit          m_known = 0, m_busy = 0, m_last_d = 1, m_d = 0, m_wr = 0;
  int          m_t = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;

  int   g_cyc[$], r_cyc[$];
  bit   g_id[$],  r_id[$];
  logic [31:0] r_rd[$];
  int   n_open = 0, n_rw = 0;

  always @(negedge clk) begin
    bit eg_i, eg_d, e_acc, e_rsp;
    eg_i = 0; eg_d = 0; e_acc = 0; e_rsp = 0;
    if (m_known) begin
      if (!m_busy) begin
        if (reset_n && (i_req_valid || d_req_valid)) begin
          eg_d = d_req_valid && (!i_req_valid || !m_last_d);
          eg_i = !eg_d;
        end
      end else begin
        e_acc = (m_t == L + 1);
        e_rsp = (m_t == L + 2);
      end
      chk1("i_req_ready", i_req_ready, eg_i);
      chk1("d_req_ready", d_req_ready, eg_d);
      chk1("mem_op_en", mem_op_en, e_acc);
      chk1("mem_rd_wr", mem_rd_wr, e_acc && m_d && m_wr);
      chk1("i_rsp_valid", i_rsp_valid, e_rsp && !m_d);
      chk1("d_rsp_valid", d_rsp_valid, e_rsp && m_d);
      chkw("rsp_rdata", rsp_rdata, m_rdata);
      if (e_acc) begin
        chkw("mem_addr", mem_addr, m_addr);
        if (m_wr) chkw("mem_wr_data", mem_wr_data, m_wdata);
      end
    end

    if (i_req_ready || d_req_ready) begin
      g_cyc.push_back(cyc);
      g_id.push_back(d_req_ready);
    end
    if (i_rsp_valid || d_rsp_valid) begin
      r_cyc.push_back(cyc);
      r_id.push_back(d_rsp_valid);
      r_rd.push_back(rsp_rdata);
    end
    if (mem_op_en) n_open++;
    if (mem_op_en && mem_rd_wr) begin
      n_rw++;
      mem_dut[mem_addr[7:0]] = mem_wr_data;
    end

    if (!reset_n) begin
      m_known = 1; m_busy = 0; m_last_d = 1; m_rdata = '0;
    end else if (m_known) begin
      if (!m_busy) begin
        if (eg_i || eg_d) begin
          m_busy = 1; m_t = 1; m_d = eg_d;
          m_wr = eg_d && d_req_wr;
          m_addr = eg_d ? d_req_addr : i_req_addr;
          m_wdata = d_req_wdata;
          m_last_d = eg_d;
        end
      end else begin
        if (e_acc) begin
          if (m_wr) ref_mem[m_addr] = m_wdata;
          else m_rdata = ref_mem.exists(m_addr) ? ref_mem[m_addr] : 32'h0;
        end
        if (e_rsp) m_busy = 0;
        else m_t++;
      end
    end
  end

  int g1_cyc[$], r1_cyc[$];
  logic [31:0] r1_rd[$];
  int n1_open = 0;
  always @(negedge clk) begin
    if (i1_ready || d1_ready) g1_cyc.push_back(cyc);
    if (i1_rsp || d1_rsp) begin
      r1_cyc.push_back(cyc);
      r1_rd.push_back(rdata1);
    end
    if (mem_en1) n1_open++;
  end

  task automatic clear_log();
    g_cyc.delete(); g_id.delete(); r_cyc.delete(); r_id.delete(); r_rd.delete();
    n_open = 0; n_rw = 0;
  endtask

  task automatic req_i(input logic [31:0] a);
    int n;
    @(posedge clk); #1;
    i_req_valid = 1'b1; i_req_addr = a;
    n = 0;
    do begin @(negedge clk); n++; end while (!i_req_ready && n < 100);
    chk1("i_handshake_timeout", i_req_ready, 1'b1);
    @(posedge clk); #1;
    i_req_valid = 1'b0;
  endtask

  task automatic req_d(input logic wr, input logic [31:0] a, input logic [31:0] wd);
    int n;
    @(posedge clk); #1;
    d_req_valid = 1'b1; d_req_wr = wr; d_req_addr = a; d_req_wdata = wd;
    n = 0;
    do begin @(negedge clk); n++; end while (!d_req_ready && n < 100);
    chk1("d_handshake_timeout", d_req_ready, 1'b1);
    @(posedge clk); #1;
    d_req_valid = 1'b0; d_req_wr = 1'b0;
  endtask

  task automatic wait_i_rsp();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!i_rsp_valid && n < 100);
    chk1("i_rsp_timeout", i_rsp_valid, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n = 1'b0;
    i_req_valid = 0; i_req_addr = '0; d_req_valid = 0; d_req_wr = 0;
    d_req_addr = '0; d_req_wdata = '0;
    i1_valid = 0; i1_addr = '0; d1_valid = 0; d1_wr = 0; d1_addr = '0; d1_wdata = '0;
    for (int i = 0; i < 256; i++) mem_dut[i] = '0;
    mem_dut[8'h10] = 32'hDEADBEEF; ref_mem[32'h10] = 32'hDEADBEEF;
    mem_dut[8'h30] = 32'h11111111; ref_mem[32'h30] = 32'h11111111;
    mem_dut[8'h40] = 32'h22222222; ref_mem[32'h40] = 32'h22222222;

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chkw("reset_rdata", rsp_rdata, 32'h0);
    chk1("reset_op_en", mem_op_en, 1'b0);
    chk1("reset_rsp", i_rsp_valid | d_rsp_valid, 1'b0);

    // Lone instruction read
    clear_log();
    req_i(32'h10);
    repeat (8) @(negedge clk);
    chkn("lone_rsp_count", r_cyc.size(), 1);
    chkn("lone_latency", r_cyc[0] - g_cyc[0], L + 2);
    chk1("lone_port_is_i", r_id[0], 1'b0);
    chkw("lone_rdata", r_rd[0], 32'hDEADBEEF);
    chkn("lone_op_en_cycles", n_open, 1);

    // Data write then read back
    clear_log();
    req_d(1'b1, 32'h20, 32'hCAFEF00D);
    repeat (8) @(negedge clk);
    req_d(1'b0, 32'h20, 32'h0);
    repeat (8) @(negedge clk);
    chkn("wr_rd_op_en_cycles", n_open, 2);
    chkn("wr_rd_rw_cycles", n_rw, 1);
    chkw("wr_keeps_rdata", r_rd[0], 32'hDEADBEEF);
    chkw("rd_after_wr", r_rd[1], 32'hCAFEF00D);
    chk1("wr_port_is_d", r_id[0], 1'b1);

    // Tie from reset, instruction side re-requests after its response
    @(posedge clk); #1 reset_n = 1'b0;
    clear_log();
    fork
      begin @(posedge clk); #1 reset_n = 1'b1; end
      begin req_i(32'h30); wait_i_rsp(); req_i(32'h40); end
      begin req_d(1'b0, 32'h20, 32'h0); end
    join
    repeat (10) @(negedge clk);
    chkn("tie_grants", g_cyc.size(), 3);
    chk1("tie_first_i", g_id[0], 1'b0);
    chk1("tie_second_d", g_id[1], 1'b1);
    chk1("tie_third_i", g_id[2], 1'b0);
    chkn("tie_gap1", g_cyc[1] - g_cyc[0], 6);
    chkn("tie_gap2", g_cyc[2] - g_cyc[1], 6);
    chk1("tie_rsp0_i", r_id[0], 1'b0);
    chk1("tie_rsp1_d", r_id[1], 1'b1);
    chkw("tie_rdata2", r_rd[2], 32'h22222222);
    chkn("tie_op_en_cycles", n_open, 3);

    // Continuous data stream with one instruction request
    clear_log();
    fork
      begin for (int k = 0; k < 4; k++) req_d(1'b0, 32'h10, 32'h0); end
      begin repeat (3) @(posedge clk); req_i(32'h40); end
    join
    repeat (10) @(negedge clk);
    chkn("stream_grants", g_cyc.size(), 5);
    chk1("stream_first_d", g_id[0], 1'b1);
    chk1("stream_i_next", g_id[1], 1'b0);
    chkn("stream_i_gap", g_cyc[1] - g_cyc[0], L + 3);
    chkn("stream_op_en_cycles", n_open, 5);

    // Reset in the second WAIT cycle aborts the transaction
    clear_log();
    @(posedge clk); #1;
    i_req_valid = 1'b1; i_req_addr = 32'h10;
    n = 0;
    do begin @(negedge clk); n++; end while (!i_req_ready && n < 100);
    chk1("abort_grant_timeout", i_req_ready, 1'b1);
    @(posedge clk); #1 i_req_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    d_req_valid = 1'b1; d_req_wr = 1'b0; d_req_addr = 32'h30;
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk1("grant_after_release", d_req_ready, 1'b1);
    @(posedge clk); #1 d_req_valid = 1'b0;
    repeat (8) @(negedge clk);
    chkn("abort_grants", g_cyc.size(), 2);
    chkn("abort_release_gap", g_cyc[1] - g_cyc[0], 3);
    chkn("abort_rsp_count", r_cyc.size(), 1);
    chk1("abort_rsp_is_d", r_id[0], 1'b1);
    chkn("abort_op_en_cycles", n_open, 1);

    // MEM_LATENCY = 1 instance
    @(posedge clk); #1;
    i1_valid = 1'b1; i1_addr = 32'h10;
    n = 0;
    do begin @(negedge clk); n++; end while (!i1_ready && n < 100);
    chk1("l1_grant_timeout", i1_ready, 1'b1);
    @(posedge clk); #1 i1_valid = 1'b0;
    repeat (6) @(negedge clk);
    chkn("l1_rsp_count", r1_cyc.size(), 1);
    chkn("l1_latency", r1_cyc[0] - g1_cyc[0], 3);
    chkw("l1_rdata", r1_rd[0], 32'hDEADBEEF);
    chkn("l1_op_en_cycles", n1_open, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LATENCY, default 3, wait cycles before each memory access; legal range 1..15.
REQ-002 Parameter CNT_W, default 4, width of the latency counter.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset_n  input  1  reset; synchronous, active-low.
REQ-005 i_req_valid  input  1  instruction-side read request.
REQ-006 i_req_addr  input  ADDR_SIZE  instruction-side byte address.
REQ-007 i_req_ready  output  1  instruction request accepted this cycle.
REQ-008 i_rsp_valid  output  1  instruction read data valid, one-cycle pulse.
REQ-009 d_req_valid  input  1  data-side request.
REQ-010 d_req_wr  input  1  data-side operation; 1 = write, 0 = read.
REQ-011 d_req_addr  input  ADDR_SIZE  data-side byte address.
REQ-012 d_req_wdata  input  WD_SIZE  data-side write data.
REQ-013 d_req_ready  output  1  data request accepted this cycle.
REQ-014 d_rsp_valid  output  1  data response valid (read data or write done), one-cycle pulse.
REQ-015 rsp_rdata  output  WD_SIZE  read data shared by both response ports.
REQ-016 mem_addr, mem_rd_wr, mem_op_en, mem_wr_data  output  ADDR_SIZE/1/1/WD_SIZE  drive the memory port.
REQ-017 mem_rd_data  input  WD_SIZE  memory read data, combinational from the memory port.

Function
REQ-018 The FSM SHALL have the states IDLE, WAIT, ACCESS and RESP.
REQ-019 In IDLE with at least one req_valid, the block SHALL grant exactly one requester, assert that requester's req_ready for that cycle, latch the granted op, address, wdata and id, load the counter with MEM_LATENCY-1, and move to WAIT.
REQ-020 req_ready SHALL be 0 in every state except IDLE.
REQ-021 When both requesters are valid in the same IDLE cycle, the grant SHALL go to the requester not granted most recently.
REQ-022 After reset, the last-granted pointer SHALL be D, so I wins the first tie.
REQ-023 A lone valid requester SHALL be granted regardless of the pointer.
REQ-024 WAIT SHALL decrement the counter each cycle and move to ACCESS in the cycle it reads 0, giving exactly MEM_LATENCY WAIT cycles.
REQ-025 ACCESS SHALL last one cycle with mem_op_en=1, mem_addr and mem_wr_data from the latched values, and mem_rd_wr=1 only for a D write.
REQ-026 On a read, ACCESS SHALL capture mem_rd_data into the rsp_rdata register at the end of the cycle.
REQ-027 RESP SHALL last one cycle and assert i_rsp_valid or d_rsp_valid, according to the latched id, then return to IDLE.
REQ-028 Response timing: a request accepted in cycle T SHALL have rsp_valid in cycle T+MEM_LATENCY+2.
REQ-029 Back-to-back throughput SHALL be one request per MEM_LATENCY+3 cycles.
REQ-030 Outside ACCESS, mem_op_en SHALL be 0 and mem_rd_wr SHALL be 0.
REQ-031 rsp_rdata SHALL hold its last value until the next read capture and SHALL NOT change on writes.
REQ-032 Requesters SHALL hold their request fields stable until ready.
REQ-033 Requests that arrive while the block is busy SHALL wait; none is dropped or duplicated.
REQ-034 Responses SHALL have no backpressure; requesters always accept them.
REQ-035 The address SHALL pass through unmodified; the memory handles alignment.

Reset
REQ-036 With reset_n=0 at a rising edge, the block SHALL enter IDLE, clear the counter, set the pointer to D, and clear rsp_rdata, the latched fields and all valid/ready/op_en outputs to 0.
REQ-037 A reset during WAIT, ACCESS or RESP SHALL abort the transaction with no response pulse.
REQ-038 From the first cycle after reset, mem_op_en SHALL be 0.
REQ-039 In the cycle reset_n returns to 1, the block SHALL be able to grant.

Structure
REQ-040 PARAMS_pkg SHALL hold ADDR_SIZE, WD_SIZE, the default MEM_LATENCY, the state typedef mem_arb_state_t and the requester-id typedef mem_req_id_t (REQ_I, REQ_D).
REQ-041 The two-way round-robin selection SHALL be a sub-module rr_arb2, with inputs req[1:0], last pointer and enable, and a one-hot grant output.
REQ-042 The FSM, counter and latches SHALL stay in mem_arbiter.

Verification (MEM_LATENCY=3, WD_SIZE=32)
REQ-043 Lone I read: I read of 0x10 accepted in cycle 5, memory word 0xDEADBEEF -> i_rsp_valid in cycle 10 with rsp_rdata=0xDEADBEEF; d_rsp_valid stays 0.
REQ-044 D write then read: D write of 0xCAFEF00D to 0x20, then D read of 0x20 -> one op_en cycle with rd_wr=1, then the read returns 0xCAFEF00D; rsp_rdata is unchanged across the write.
REQ-045 Tie sequence: I and D valid together from reset, with I re-requesting after its response -> grant order I, D, I; each rsp_valid is on the correct port and there are 6 cycles between grants.
REQ-046 Continuous D stream plus a single I request -> I is granted on the next IDLE and is not starved.
REQ-047 Reset during WAIT: reset_n=0 for one cycle in the second WAIT cycle -> no rsp_valid, no op_en, and the block grants again in the cycle after release.
REQ-048 Boundaries: MEM_LATENCY=1 -> response at T+3; mem_op_en is high for exactly one cycle per transaction in every test.
